// File: rtl/alu_pkg.sv
// Shared ALU encodings and op decode for the operand stage and its forwarding muxes.
package alu_pkg;

  localparam int RBITS_DEFAULT = 5;

  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_AND = 2'b10;

  typedef struct packed {
    logic cin;
    logic c2;
    logic inv_b;
  } alu_ctl_t;

  localparam alu_ctl_t CTL_ADD = '{cin: 1'b0, c2: 1'b1, inv_b: 1'b0};
  localparam alu_ctl_t CTL_SUB = '{cin: 1'b1, c2: 1'b1, inv_b: 1'b1};
  localparam alu_ctl_t CTL_AND = '{cin: 1'b0, c2: 1'b0, inv_b: 1'b0};

  // Reserved encodings fall back to ADD.
  function automatic alu_ctl_t decode_op(input logic [1:0] op);
    alu_ctl_t ctl;
    case (op)
      ALU_OP_ADD: ctl = CTL_ADD;
      ALU_OP_SUB: ctl = CTL_SUB;
      ALU_OP_AND: ctl = CTL_AND;
      default:    ctl = CTL_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Forwarding select for one source operand; EX/MEM beats MEM/WB, register 0 never forwards.
module fwd_mux
  import alu_pkg::*;
#(
  parameter int bus   = 8,
  parameter int rbits = RBITS_DEFAULT
) (
  input  logic [rbits-1:0] src_addr,
  input  logic [bus-1:0]   rf_data,
  input  logic             exm_wr,
  input  logic [rbits-1:0] exm_addr,
  input  logic [bus-1:0]   exm_data,
  input  logic             mwb_wr,
  input  logic [rbits-1:0] mwb_addr,
  input  logic [bus-1:0]   mwb_data,
  output logic [bus-1:0]   data
);

  logic src_nz_s;

  assign src_nz_s = (src_addr != {rbits{1'b0}});

  // Priority select between the two pending writes and the register file.
  always_comb begin
    data = rf_data;
    if (src_nz_s && exm_wr && (exm_addr == src_addr)) begin
      data = exm_data;
    end else if (src_nz_s && mwb_wr && (mwb_addr == src_addr)) begin
      data = mwb_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage feeding the ALU. Define ALU_STAGE_FWD_EN for forwarding;
// otherwise the stage stalls on pending writes to a used source register.
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int bus   = 8,
  parameter int rbits = RBITS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [rbits-1:0] rs_addr,
  input  logic [rbits-1:0] rt_addr,
  input  logic [bus-1:0]   rs_data,
  input  logic [bus-1:0]   rt_data,
  input  logic [bus-1:0]   imm,
  input  logic             use_imm,
  input  logic [1:0]       op,
  input  logic [rbits-1:0] rd_addr,
  input  logic             exm_wr,
  input  logic [rbits-1:0] exm_addr,
  input  logic [bus-1:0]   exm_data,
  input  logic             mwb_wr,
  input  logic [rbits-1:0] mwb_addr,
  input  logic [bus-1:0]   mwb_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [bus-1:0]   a,
  output logic [bus-1:0]   b,
  output logic             cin,
  output logic             c2,
  output logic [rbits-1:0] rd_out
);

  logic [bus-1:0] rs_val_s;
  logic [bus-1:0] rt_val_s;
  logic [bus-1:0] b_sel_s;
  logic [bus-1:0] b_fin_s;
  alu_ctl_t       ctl_s;
  logic           hazard_s;
  logic           capture_s;

`ifdef ALU_STAGE_FWD_EN
  fwd_mux #(.bus(bus), .rbits(rbits)) u_fwd_rs (
    .src_addr(rs_addr), .rf_data(rs_data),
    .exm_wr(exm_wr), .exm_addr(exm_addr), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_addr(mwb_addr), .mwb_data(mwb_data),
    .data(rs_val_s)
  );

  fwd_mux #(.bus(bus), .rbits(rbits)) u_fwd_rt (
    .src_addr(rt_addr), .rf_data(rt_data),
    .exm_wr(exm_wr), .exm_addr(exm_addr), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_addr(mwb_addr), .mwb_data(mwb_data),
    .data(rt_val_s)
  );

  assign hazard_s = 1'b0;
`else
  logic rs_hit_s;
  logic rt_hit_s;
  logic unused_data_s;

  assign rs_val_s = rs_data;
  assign rt_val_s = rt_data;
  assign rs_hit_s = (rs_addr != {rbits{1'b0}}) &&
                    ((exm_wr && (exm_addr == rs_addr)) || (mwb_wr && (mwb_addr == rs_addr)));
  assign rt_hit_s = (rt_addr != {rbits{1'b0}}) &&
                    ((exm_wr && (exm_addr == rt_addr)) || (mwb_wr && (mwb_addr == rt_addr)));
  // rt only matters when operand B actually comes from the register file.
  assign hazard_s = rs_hit_s || (rt_hit_s && !use_imm);
  assign unused_data_s = ^{exm_data, mwb_data};
`endif

  assign ctl_s     = decode_op(op);
  assign b_sel_s   = use_imm ? imm : rt_val_s;
  assign b_fin_s   = ctl_s.inv_b ? ~b_sel_s : b_sel_s;
  assign in_ready  = (!out_valid || out_ready) && !hazard_s;
  assign capture_s = in_valid && in_ready && !flush;

  // Output bundle register: reset, then flush, then capture, then drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= {bus{1'b0}};
      b         <= {bus{1'b0}};
      cin       <= 1'b0;
      c2        <= 1'b0;
      rd_out    <= {rbits{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture_s) begin
      out_valid <= 1'b1;
      a         <= rs_val_s;
      b         <= b_fin_s;
      cin       <= ctl_s.cin;
      c2        <= ctl_s.c2;
      rd_out    <= rd_addr;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed vectors push expected bundles, a monitor pops on transfer.
module tb_alu_operand_stage;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       c2;
    logic [4:0] rd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, use_imm, flush, out_valid, out_ready, cin, c2;
  logic [4:0] rs_addr, rt_addr, rd_addr, exm_addr, mwb_addr, rd_out;
  logic [7:0] rs_data, rt_data, imm, exm_data, mwb_data, a, b;
  logic [1:0] op;
  logic       exm_wr, mwb_wr;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .use_imm(use_imm), .op(op), .rd_addr(rd_addr),
    .exm_wr(exm_wr), .exm_addr(exm_addr), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_addr(mwb_addr), .mwb_data(mwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .cin(cin), .c2(c2), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest expected bundle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got a=%0h b=%0h with empty scoreboard", a, b);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("bundle{a,b,cin,c2,rd}", {9'd0, a, b, cin, c2, rd_out}, {9'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_hz();
    exm_wr = 1'b0; exm_addr = 5'd0; exm_data = 8'h00;
    mwb_wr = 1'b0; mwb_addr = 5'd0; mwb_data = 8'h00;
  endtask

  task automatic set_in(input logic [4:0] rsa, input logic [7:0] rsd,
                        input logic [4:0] rta, input logic [7:0] rtd,
                        input logic [7:0] im, input logic ui,
                        input logic [1:0] o, input logic [4:0] rd);
    in_valid = 1'b1;
    rs_addr = rsa; rs_data = rsd; rt_addr = rta; rt_data = rtd;
    imm = im; use_imm = ui; op = o; rd_addr = rd;
  endtask

  task automatic issue(input logic [4:0] rsa, input logic [7:0] rsd,
                       input logic [4:0] rta, input logic [7:0] rtd,
                       input logic [7:0] im, input logic ui,
                       input logic [1:0] o, input logic [4:0] rd,
                       input logic acc, input exp_t e);
    set_in(rsa, rsd, rta, rtd, im, ui, o, rd);
    if (acc) sb_q.push_back(e);
    step();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    rs_data = 8'h00; rt_data = 8'h00; imm = 8'h00; use_imm = 1'b0; op = 2'b00;
    clr_hz();
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_a", {24'd0, a}, 32'd0);
    chk("reset_b", {24'd0, b}, 32'd0);
    chk("reset_cin", {31'd0, cin}, 32'd0);
    chk("reset_c2", {31'd0, c2}, 32'd0);
    chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Op coverage, back-to-back at full throughput.
    issue(5'd3, 8'h12, 5'd4, 8'h05, 8'h00, 1'b0, ALU_OP_SUB, 5'd7, 1'b1, '{8'h12, 8'hFA, 1'b1, 1'b1, 5'd7});
    issue(5'd1, 8'h01, 5'd2, 8'h77, 8'h80, 1'b1, ALU_OP_ADD, 5'd8, 1'b1, '{8'h01, 8'h80, 1'b0, 1'b1, 5'd8});
    issue(5'd2, 8'hF0, 5'd3, 8'h3C, 8'h00, 1'b0, ALU_OP_AND, 5'd9, 1'b1, '{8'hF0, 8'h3C, 1'b0, 1'b0, 5'd9});
    issue(5'd4, 8'h55, 5'd5, 8'h0F, 8'h00, 1'b0, 2'b11,      5'd10, 1'b1, '{8'h55, 8'h0F, 1'b0, 1'b1, 5'd10});
    // Register 0 never forwards nor stalls.
    exm_wr = 1'b1; exm_addr = 5'd0; exm_data = 8'hEE;
    issue(5'd0, 8'h33, 5'd1, 8'h02, 8'h00, 1'b0, ALU_OP_ADD, 5'd1, 1'b1, '{8'h33, 8'h02, 1'b0, 1'b1, 5'd1});
    clr_hz();
    // rt matches a pending write but B comes from imm.
    mwb_wr = 1'b1; mwb_addr = 5'd6; mwb_data = 8'h99;
    issue(5'd1, 8'h01, 5'd6, 8'h20, 8'h80, 1'b1, ALU_OP_SUB, 5'd2, 1'b1, '{8'h01, 8'h7F, 1'b1, 1'b1, 5'd2});
    clr_hz();
    in_valid = 1'b0;
    step();

`ifdef ALU_STAGE_FWD_EN
    exm_wr = 1'b1; exm_addr = 5'd5; exm_data = 8'h7E;
    mwb_wr = 1'b1; mwb_addr = 5'd5; mwb_data = 8'h11;
    issue(5'd5, 8'h00, 5'd0, 8'h01, 8'h00, 1'b0, ALU_OP_ADD, 5'd3, 1'b1, '{8'h7E, 8'h01, 1'b0, 1'b1, 5'd3});
    exm_wr = 1'b0;
    issue(5'd5, 8'h00, 5'd0, 8'h01, 8'h00, 1'b0, ALU_OP_ADD, 5'd3, 1'b1, '{8'h11, 8'h01, 1'b0, 1'b1, 5'd3});
    clr_hz();
    mwb_wr = 1'b1; mwb_addr = 5'd9; mwb_data = 8'h44;
    issue(5'd0, 8'h10, 5'd9, 8'h01, 8'h00, 1'b0, ALU_OP_SUB, 5'd4, 1'b1, '{8'h10, 8'hBB, 1'b1, 1'b1, 5'd4});
    clr_hz();
    mwb_wr = 1'b1; mwb_addr = 5'd6; mwb_data = 8'h99;
    set_in(5'd2, 8'h10, 5'd6, 8'h20, 8'h00, 1'b0, ALU_OP_ADD, 5'd11);
    @(negedge clk);
    chk("fwd_no_stall_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.push_back('{8'h10, 8'h99, 1'b0, 1'b1, 5'd11});
    step();
    clr_hz();
`else
    mwb_wr = 1'b1; mwb_addr = 5'd6; mwb_data = 8'h99;
    set_in(5'd2, 8'h10, 5'd6, 8'h20, 8'h00, 1'b0, ALU_OP_ADD, 5'd11);
    @(negedge clk);
    chk("stall_rt_in_ready_c0", {31'd0, in_ready}, 32'd0);
    step();
    @(negedge clk);
    chk("stall_rt_in_ready_c1", {31'd0, in_ready}, 32'd0);
    chk("stall_rt_out_valid", {31'd0, out_valid}, 32'd0);
    mwb_wr = 1'b0;
    sb_q.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 5'd11});
    #1;
    chk("stall_rt_release", {31'd0, in_ready}, 32'd1);
    step();
    exm_wr = 1'b1; exm_addr = 5'd5; exm_data = 8'h7E;
    set_in(5'd5, 8'h21, 5'd0, 8'h01, 8'h00, 1'b0, ALU_OP_ADD, 5'd12);
    @(negedge clk);
    chk("stall_rs_exm_in_ready", {31'd0, in_ready}, 32'd0);
    exm_wr = 1'b0;
    sb_q.push_back('{8'h21, 8'h01, 1'b0, 1'b1, 5'd12});
    step();
    clr_hz();
`endif
    in_valid = 1'b0;
    step();

    // Hold under backpressure, then back-to-back transfer.
    out_ready = 1'b0;
    issue(5'd7, 8'hA5, 5'd8, 8'h5A, 8'h00, 1'b0, ALU_OP_AND, 5'd13, 1'b1, '{8'hA5, 8'h5A, 1'b0, 1'b0, 5'd13});
    set_in(5'd9, 8'h0C, 5'd10, 8'h03, 8'h00, 1'b0, ALU_OP_SUB, 5'd14);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_a_b", {16'd0, a, b}, {16'd0, 8'hA5, 8'h5A});
      rs_data = rs_data + 8'd1;
      step();
    end
    rs_data = 8'h0C;
    out_ready = 1'b1;
    sb_q.push_back('{8'h0C, 8'hFC, 1'b1, 1'b1, 5'd14});
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_out_valid", {31'd0, out_valid}, 32'd1);
    step();

    // Flush coincident with an incoming instruction.
    flush = 1'b1;
    set_in(5'd1, 8'h66, 5'd2, 8'h11, 8'h00, 1'b0, ALU_OP_ADD, 5'd15);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset while a bundle is held.
    out_ready = 1'b0;
    issue(5'd1, 8'h9C, 5'd2, 8'h21, 8'h00, 1'b0, ALU_OP_SUB, 5'd16, 1'b0, '{8'h00, 8'h00, 1'b0, 1'b0, 5'd0});
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_outputs", {8'd0, out_valid, a, b, cin, c2, rd_out}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

ID/EX pipeline stage that sits directly upstream of the `ALU`. It accepts a decoded instruction from the decode stage and resolves both operands, including EX/MEM and MEM/WB forwarding. It registers the ALU operand and control bundle (`a`, `b`, `cin`, `c2`) together with the destination register. A valid/ready handshake provides stall and flush control.

## Interface
- `bus`, 8: datapath width; matches the `ALU` it feeds.
- `rbits`, 5: register-address width.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: decode stage presents an instruction.
- `in_ready` out 1: the stage can accept this cycle.
- `rs_addr`, `rt_addr` in `rbits`: source register numbers.
- `rs_data`, `rt_data` in `bus`: register-file read data.
- `imm` in `bus`: sign-extended immediate.
- `use_imm` in 1: operand B = `imm` instead of rt.
- `op` in 2: ALU operation; see Operation.
- `rd_addr` in `rbits`: destination register.
- `exm_wr`, `exm_addr`, `exm_data` in 1/`rbits`/`bus`: pending EX/MEM write.
- `mwb_wr`, `mwb_addr`, `mwb_data` in 1/`rbits`/`bus`: pending MEM/WB write.
- `flush` in 1: kill held and incoming instruction.
- `out_valid` out 1: registered bundle is valid.
- `out_ready` in 1: downstream (EX) accepts.
- `a`, `b` out `bus`: ALU operands.
- `cin`, `c2` out 1: ALU carry-in and complement/and select.
- `rd_out` out `rbits`: registered destination.

## Operation
- Operand A is rs, after forwarding.
- Operand B is `imm` if `use_imm`; otherwise rt, after forwarding.
- Forwarding per source:
  - If `exm_wr` and `exm_addr` == src and src != 0, use `exm_data`.
  - Else if `mwb_wr` and `mwb_addr` == src and src != 0, use `mwb_data`.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 always reads as the register-file value.
- `op` mapping to (`b` out, `cin`, `c2`):

| `op` | Name | `b` out | `cin` | `c2` |
|---|---|---|---|---|
| 00 | ADD | B | 0 | 1 |
| 01 | SUB | ~B | 1 | 1 |
| 10 | AND | B | 0 | 0 |
| 11 | reserved | as ADD | 0 | 1 |

- `in_ready` = !`out_valid` || `out_ready`.
- Capture occurs when `in_valid` && `in_ready` && !`flush`. On capture, load all outputs and set `out_valid`.
- If `out_ready` && `out_valid` and there is no capture, clear `out_valid`.
- Otherwise hold. Outputs are stable while `out_valid` && !`out_ready`.
- Forwarding is sampled only in the capture cycle. A held bundle is never re-forwarded.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`. Throughput is 1 per cycle when `out_ready` = 1.
- Reset values: `out_valid`=0, `a`=0, `b`=0, `cin`=0, `c2`=0, `rd_out`=0. `in_ready`=1 after reset.
- `rst` mid-operation discards the held bundle. `rst` has priority over `flush`, which has priority over capture.
- `flush` with `in_valid`: the next cycle has `out_valid`=0 and nothing is captured.
- Simultaneous accept downstream and capture upstream: new data replaces old with `out_valid` staying 1, so there is no bubble.
- `in_ready` is combinational from `out_valid`/`out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `ALU_STAGE_FWD_EN` defined: forwarding as above.
- `ALU_STAGE_FWD_EN` undefined:
  - Forwarding muxes are removed and operands come only from `rs_data`/`rt_data`/`imm`.
  - `in_ready` is additionally forced 0 while any used source (rt only when !`use_imm`), nonzero, matches `exm_addr` with `exm_wr` or `mwb_addr` with `mwb_wr`. This stalls until the write retires.

## Structure
- Shared package `alu_pkg` holds:
  - `op` encodings `ALU_OP_ADD`/`SUB`/`AND`.
  - The `op`→(`cin`, `c2`, invert-B) decode constants.
  - The `rbits` default.
- Sub-module `fwd_mux`: one source's forwarding select, instantiated twice (rs, rt). It is omitted when `ALU_STAGE_FWD_EN` is undefined.

## Test plan
- Reset, then `in_valid`=1 with rs=3 (0x12), rt=4 (0x05), `op`=SUB, no hazards → next cycle `a`=0x12, `b`=0xFA, `cin`=1, `c2`=1, `out_valid`=1.
- rs=5 with `exm_wr`=1/`exm_addr`=5/`exm_data`=0x7E and `mwb_wr`=1/`mwb_addr`=5/`mwb_data`=0x11 → `a`=0x7E. Repeat with `exm_wr`=0 → `a`=0x11.
- rs=0 with `exm_addr`=0 and `exm_wr`=1 → `a` = `rs_data`, with no forwarding.
- `out_ready`=0 for 3 cycles while holding → `in_ready`=0 and outputs stable. On `out_ready`=1 with a new input: back-to-back transfer with no bubble.
- `flush`=1 coincident with `in_valid` → `out_valid`=0 next cycle. `rst` during held valid → all outputs zero.
- Without `ALU_STAGE_FWD_EN`: rt=6, `mwb_wr`=1/`mwb_addr`=6 → `in_ready`=0 until `mwb_wr` drops, then capture.
